bcd_scan_display: RTL and testbench
===================================

BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 4, giving the clock cycles per digit slot (legal range 1..65535).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on the posedge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port en  input  1  scan enable; when low, the prescaler and scan index hold.
REQ-005 The block SHALL have port load  input  1  single-cycle strobe that snapshots the digits input.
REQ-006 The block SHALL have port digits  input  16  four BCD digits from a chain of decade counters; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 The block SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-008 The block SHALL have port seg  output  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
REQ-009 The block SHALL have port an  output  4  digit select, one-hot, active-high; an[i] selects digit i.
REQ-010 The block SHALL have port err  output  1  sticky flag indicating a non-BCD nibble in the snapshot.

Function
REQ-011 The prescaler SHALL count 0..REFRESH_DIV-1 while en=1 and emit an internal tick on the cycle it holds REFRESH_DIV-1, then wrap to 0.
REQ-012 A 2-bit scan index SHALL advance 0->1->2->3->0 on each tick; with REFRESH_DIV=1 it SHALL advance every enabled cycle.
REQ-013 With en=0, the prescaler and scan index SHALL hold their values, and load SHALL still be honoured.
REQ-014 On a load=1 edge, the snapshot SHALL take digits; seg SHALL reflect the new snapshot from the next cycle onward.
REQ-015 Load and tick in the same cycle SHALL both take effect: new snapshot and advanced index.
REQ-016 an SHALL be the one-hot decode of the scan index, and seg SHALL be the decode of the selected snapshot nibble; both SHALL derive from registers only, with no combinational path from inputs.
REQ-017 The decode SHALL be 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex).
REQ-018 A nibble of 10..15 SHALL display a dash (seg=7'h40).
REQ-019 err SHALL set on a load whose data contains any nibble above 9, and SHALL clear on a load whose data contains only valid nibbles.
REQ-020 Leading-zero blanking: with blank_lz=1, digit i (i=1..3) SHALL drive seg=0 when snapshot digits i..3 are all zero; digit 0 SHALL never blank.
REQ-021 Blanking SHALL affect seg only; an SHALL continue scanning.
REQ-022 blank_lz SHALL be sampled combinationally against the registered snapshot and SHALL take effect in the same cycle.

Reset
REQ-023 While rst=0, the block SHALL asynchronously set prescaler=0, index=0, snapshot=16'h0000 and err=0, giving an=4'b0001 and seg=7'h3F.
REQ-024 Reset asserted mid-scan SHALL abort immediately; after release, the first tick SHALL occur REFRESH_DIV enabled cycles later.

Structure
REQ-025 A shared package SHALL hold the segment encoding constants (digits 0-9, dash, blank) and the default REFRESH_DIV.
REQ-026 A combinational sub-module bcd_to_7seg (4-bit in, 7-bit seg out, using the package constants) SHALL perform the decode and SHALL be instantiated once.
REQ-027 The prescaler width SHALL be 16 bits.

Verification
REQ-028 Reset then release with en=1 and REFRESH_DIV=4 -> an sequence 0001,0010,0100,1000,0001, each held exactly 4 cycles.
REQ-029 load with digits=16'h1234 -> at an=0001 seg=66, an=0010 seg=4F, an=0100 seg=5B, an=1000 seg=06.
REQ-030 load with digits=16'h0047 and blank_lz=1 -> digits 3 and 2 show seg=00, digit 1 shows 66, digit 0 shows 07; with blank_lz=0, digits 3 and 2 show 3F.
REQ-031 load with digits=16'h00A5 -> err=1 and digit 1 shows 40; a following load of 16'h0005 -> err=0.
REQ-032 en=0 for 10 cycles mid-slot -> an frozen and prescaler held; a load of 16'h9999 during this window -> seg=6F next cycle.
REQ-033 rst pulsed low asynchronously mid-slot with an=0100 -> immediately an=0001, seg=3F, err=0.

Source files
------------

// File: rtl/bcd_scan_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_scan_display_pkg
// Description : Shared constants for the multiplexed BCD display: segment
//               glyphs ({g,f,e,d,c,b,a}, active-high), prescaler width and
//               default refresh divider.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_scan_display_pkg;

    localparam int unsigned c_REFRESH_DIV_DEFAULT = 4;
    localparam int          c_PRESC_W             = 16;

    localparam logic [6:0] c_SEG_0     = 7'h3F;
    localparam logic [6:0] c_SEG_1     = 7'h06;
    localparam logic [6:0] c_SEG_2     = 7'h5B;
    localparam logic [6:0] c_SEG_3     = 7'h4F;
    localparam logic [6:0] c_SEG_4     = 7'h66;
    localparam logic [6:0] c_SEG_5     = 7'h6D;
    localparam logic [6:0] c_SEG_6     = 7'h7D;
    localparam logic [6:0] c_SEG_7     = 7'h07;
    localparam logic [6:0] c_SEG_8     = 7'h7F;
    localparam logic [6:0] c_SEG_9     = 7'h6F;
    localparam logic [6:0] c_SEG_DASH  = 7'h40;
    localparam logic [6:0] c_SEG_BLANK = 7'h00;

endpackage
`default_nettype wire

// File: rtl/bcd_scan_display_bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_7seg
// Description : Combinational BCD to seven-segment decoder. Codes 10..15 are
//               not BCD and are shown as a dash.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
    import bcd_scan_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Glyph lookup; anything outside 0..9 renders as a dash
    always_comb begin
        o_seg = c_SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = c_SEG_0;
            4'd1:    o_seg = c_SEG_1;
            4'd2:    o_seg = c_SEG_2;
            4'd3:    o_seg = c_SEG_3;
            4'd4:    o_seg = c_SEG_4;
            4'd5:    o_seg = c_SEG_5;
            4'd6:    o_seg = c_SEG_6;
            4'd7:    o_seg = c_SEG_7;
            4'd8:    o_seg = c_SEG_8;
            4'd9:    o_seg = c_SEG_9;
            default: o_seg = c_SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : bcd_scan_display
// Description : Four-digit multiplexed BCD display driver. A prescaler sets
//               the time per digit slot, a 2-bit index scans the anodes, and
//               the selected digit of a loaded snapshot is decoded to segments
//               with optional leading-zero blanking and a sticky-until-reload
//               invalid-digit flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = c_REFRESH_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        err
);

    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(REFRESH_DIV - 1);

    logic [c_PRESC_W-1:0] r_presc_q, w_presc_d;
    logic [1:0]           r_idx_q,   w_idx_d;
    logic [15:0]          r_snap_q,  w_snap_d;
    logic                 r_err_q,   w_err_d;
    logic                 w_tick;
    logic                 w_bad_digit;
    logic [3:0]           w_nibble;
    logic [6:0]           w_seg_dec;
    logic                 w_upper_zero;

    // Next-state: prescaler/index advance only while enabled; load is independent
    always_comb begin
        w_tick      = en && (r_presc_q == c_PRESC_MAX);
        w_presc_d   = r_presc_q;
        w_idx_d     = r_idx_q;
        w_bad_digit = 1'b0;
        if (en) begin
            if (w_tick) begin
                w_presc_d = '0;
                w_idx_d   = r_idx_q + 2'd1;
            end else begin
                w_presc_d = r_presc_q + 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (digits[i*4 +: 4] > 4'd9) begin
                w_bad_digit = 1'b1;
            end
        end
        w_snap_d = load ? digits      : r_snap_q;
        w_err_d  = load ? w_bad_digit : r_err_q;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc_q <= '0;
            r_idx_q   <= 2'd0;
            r_snap_q  <= 16'h0000;
            r_err_q   <= 1'b0;
        end else begin
            r_presc_q <= w_presc_d;
            r_idx_q   <= w_idx_d;
            r_snap_q  <= w_snap_d;
            r_err_q   <= w_err_d;
        end
    end

    // Select the scanned nibble and detect that it and all digits above it are zero
    always_comb begin
        w_nibble     = r_snap_q[3:0];
        w_upper_zero = 1'b0;
        case (r_idx_q)
            2'd0: begin
                w_nibble     = r_snap_q[3:0];
                w_upper_zero = 1'b0;
            end
            2'd1: begin
                w_nibble     = r_snap_q[7:4];
                w_upper_zero = (r_snap_q[15:4] == 12'h000);
            end
            2'd2: begin
                w_nibble     = r_snap_q[11:8];
                w_upper_zero = (r_snap_q[15:8] == 8'h00);
            end
            default: begin
                w_nibble     = r_snap_q[15:12];
                w_upper_zero = (r_snap_q[15:12] == 4'h0);
            end
        endcase
    end

    bcd_to_7seg u_dec (
        .i_bcd (w_nibble),
        .o_seg (w_seg_dec)
    );

    assign seg = (blank_lz && w_upper_zero) ? c_SEG_BLANK : w_seg_dec;
    assign an  = 4'b0001 << r_idx_q;
    assign err = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_scan_display
// Description : Self-checking bench for bcd_scan_display. A reference model
//               tracks enabled-cycle count, snapshot and error flag, and
//               derives the expected anode and segment outputs arithmetically.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_en_cnt = 0;
    logic [15:0] m_snap   = 16'h0000;
    logic        m_err    = 1'b0;

    always #5 clk = ~clk;

    bcd_scan_display #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .digits   (digits),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .err      (err)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic int m_idx();
        return (m_en_cnt / DIV) % 4;
    endfunction

    function automatic logic [6:0] m_seg();
        int i;
        int d;
        i = m_idx();
        d = int'((m_snap >> (4 * i)) & 16'h000F);
        if (blank_lz && i > 0 && (m_snap >> (4 * i)) == 16'h0000) return 7'h00;
        return glyph(d);
    endfunction

    // One clock: update model with the inputs seen at the edge, then compare
    task automatic step();
        @(posedge clk);
        if (load) begin
            m_snap = digits;
            m_err  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (((digits >> (4 * i)) & 16'h000F) > 16'd9) m_err = 1'b1;
            end
        end
        if (en) m_en_cnt++;
        #1;
        check("an",  16'(an),  16'(4'b0001 << m_idx()));
        check("seg", 16'(seg), 16'(m_seg()));
        check("err", 16'(err), 16'(m_err));
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic pulse_reset();
        #3;
        rst = 1'b0;
        #1;
        check("rst_an",  16'(an),  16'h0001);
        check("rst_seg", 16'(seg), 16'h003F);
        check("rst_err", 16'(err), 16'h0000);
        m_en_cnt = 0;
        m_snap   = 16'h0000;
        m_err    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Power-on reset held across edges
        repeat (2) @(posedge clk);
        #1;
        check("por_an",  16'(an),  16'h0001);
        check("por_seg", 16'(seg), 16'h003F);
        check("por_err", 16'(err), 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // Free-running scan timing
        en = 1'b1;
        repeat (20) step();

        // Plain digits
        load = 1'b1; digits = 16'h1234;
        step();
        load = 1'b0;
        repeat (16) step();

        // Leading-zero blanking on and off
        load = 1'b1; digits = 16'h0047; blank_lz = 1'b1;
        step();
        load = 1'b0;
        repeat (16) step();
        blank_lz = 1'b0;
        repeat (16) step();

        // Invalid nibble sets err, valid reload clears it
        load = 1'b1; digits = 16'h00A5;
        step();
        load = 1'b0;
        check("err_set", 16'(err), 16'h0001);
        repeat (16) step();
        load = 1'b1; digits = 16'h0005;
        step();
        load = 1'b0;
        check("err_clr", 16'(err), 16'h0000);

        // Freeze mid-slot, load while frozen
        for (int k = 0; k < 20 && (m_en_cnt % DIV) != 2; k++) step();
        check("reach_mid", 16'((m_en_cnt % DIV) == 2), 16'h0001);
        en = 1'b0;
        repeat (4) step();
        load = 1'b1; digits = 16'h9999;
        step();
        load = 1'b0;
        check("seg_9999", 16'(seg), 16'h006F);
        repeat (5) step();
        en = 1'b1;
        repeat (12) step();

        // Reset mid-slot while digit 2 is selected
        load = 1'b1; digits = 16'h5678;
        step();
        load = 1'b0;
        for (int k = 0; k < 40 && !(m_idx() == 2 && (m_en_cnt % DIV) == 1); k++) step();
        check("reach_d2", 16'(an), 16'h0004);
        pulse_reset();
        repeat (12) step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            en       = ($urandom_range(0, 3) != 0);
            load     = ($urandom_range(0, 4) == 0);
            blank_lz = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 1) == 1) begin
                digits = 16'($urandom);
            end else begin
                for (int i = 0; i < 4; i++) digits[i*4 +: 4] = 4'($urandom_range(0, 9));
            end
            digits = digits >> (4 * $urandom_range(0, 3));
            step();
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
